// File: rtl/uart_pkg.sv
// Definitions shared by the board UART receiver and transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_TICKS_PER_BIT = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous pin inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic resetN,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, one-entry valid/ready holding register,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      serialIn,
  output logic [UART_DATA_BITS-1:0] receiveData,
  output logic                      receiveValid,
  input  logic                      receiveReady,
  output logic                      framingError,
  output logic                      overrun
);

  localparam int CW = $clog2(TICKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  // Counter restarts at 0 on entry, so a sample at tick N lands on count N-1.
  localparam logic [CW-1:0] TICK_HALF = CW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

  logic                      line_s;
  logic                      line_q;
  logic                      fall;
  uart_state_e               state_q, state_d;
  logic [CW-1:0]             tick_q, tick_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      byte_done;
  logic                      frame_err;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      ferr_q;
  logic                      ovr_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock  (clock),
    .resetN (resetN),
    .d_i    (serialIn),
    .q_o    (line_s)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) line_q <= 1'b1;
    else         line_q <= line_s;
  end

  assign fall = line_q & ~line_s;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = line_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {line_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (line_s) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line must go high before another start edge is accepted.
        tick_d = '0;
        if (line_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= frame_err;
      ovr_q  <= 1'b0;
      if (byte_done) begin
        if (valid_q && !receiveReady) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && receiveReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign receiveData  = data_q;
  assign receiveValid = valid_q;
  assign framingError = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at three bit periods (16, 48, 5 clocks per bit).
module tb_uart_rx;

  typedef enum logic [1:0] {EV_DATA, EV_FE, EV_OVR} ev_e;
  typedef struct {
    int         inst;
    ev_e        kind;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic       clock = 1'b0;
  logic       rstn;
  logic       ser   [3];
  logic       rdy   [3];
  logic [7:0] rdata [3];
  logic       valid [3];
  logic       fe    [3];
  logic       ov    [3];

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    uart_rx #(.TICKS_PER_BIT(gi == 0 ? 16 : (gi == 1 ? 48 : 5))) u_dut (
      .clock        (clock),
      .resetN       (rstn),
      .serialIn     (ser[gi]),
      .receiveData  (rdata[gi]),
      .receiveValid (valid[gi]),
      .receiveReady (rdy[gi]),
      .framingError (fe[gi]),
      .overrun      (ov[gi])
    );
  end

  function automatic int tpb(input int i);
    case (i)
      0:       return 16;
      1:       return 48;
      default: return 5;
    endcase
  endfunction

  function automatic void expect_ev(input int i, input ev_e k, input logic [7:0] d);
    exp_t e;
    e.inst = i;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endfunction

  task automatic check_ev(input int i, input ev_e k, input logic [7:0] d);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got inst %0d %s %02h, nothing required", i, k.name(), d);
    end else begin
      e = sb.pop_front();
      if (e.inst != i || e.kind != k || (k != EV_FE && e.data !== d)) begin
        n_fail++;
        $display("FAIL sb_event: got inst %0d %s %02h, required inst %0d %s %02h",
                 i, k.name(), d, e.inst, e.kind.name(), e.data);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h", nm, act, exp);
    end
  endtask

  // Monitor: sample one time unit after the falling edge, when inputs are settled.
  always @(negedge clock) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (fe[i])              check_ev(i, EV_FE,   rdata[i]);
      if (ov[i])              check_ev(i, EV_OVR,  rdata[i]);
      if (valid[i] && rdy[i]) check_ev(i, EV_DATA, rdata[i]);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called on a falling clock edge; returns on one, with the stop level still driven.
  task automatic send_frame(input int i, input logic [7:0] d, input logic stop);
    int t;
    t = tpb(i);
    ser[i] = 1'b0;
    idle(t);
    for (int k = 0; k < 8; k++) begin
      ser[i] = d[k];
      idle(t);
    end
    ser[i] = stop;
    idle(t);
  endtask

  task automatic send_partial(input int i, input logic [7:0] d);
    int t;
    t = tpb(i);
    ser[i] = 1'b0;
    idle(t);
    for (int k = 0; k < 4; k++) begin
      ser[i] = d[k];
      idle(t);
    end
    ser[i] = d[4];
    idle(t / 2);
  endtask

  // Stop sample falls in the cycle that starts at rising edge 2+T/2+9T after the start drive.
  task automatic single_byte(input int i, input logic [7:0] d);
    int t;
    int w;
    t = tpb(i);
    w = 2 + t / 2 + 9 * t;
    expect_ev(i, EV_DATA, d);
    fork
      send_frame(i, d, 1'b1);
      begin
        repeat (w) @(posedge clock);
        @(negedge clock);
        chk($sformatf("valid_early_%0d", i), 8'(valid[i]), 8'd0);
        @(posedge clock);
        @(negedge clock);
        chk($sformatf("valid_rise_%0d", i), 8'(valid[i]), 8'd1);
        chk($sformatf("data_rise_%0d", i), rdata[i], d);
        @(posedge clock);
        @(negedge clock);
        chk($sformatf("valid_fall_%0d", i), 8'(valid[i]), 8'd0);
      end
    join
    idle(2 * t);
  endtask

  initial begin
    exp_t e;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser[i] = 1'b1;
      rdy[i] = 1'b0;
    end
    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_data_%0d", i),  rdata[i],      8'h00);
      chk($sformatf("rst_valid_%0d", i), 8'(valid[i]),  8'd0);
      chk($sformatf("rst_ferr_%0d", i),  8'(fe[i]),     8'd0);
      chk($sformatf("rst_ovr_%0d", i),   8'(ov[i]),     8'd0);
    end
    rstn = 1'b1;
    idle(5);

    // Single byte with consumer always ready
    rdy[0] = 1'b1;
    single_byte(0, 8'h55);

    // Back-to-back frames while the consumer stalls
    rdy[0] = 1'b0;
    expect_ev(0, EV_OVR,  8'hA3);
    expect_ev(0, EV_DATA, 8'hA3);
    send_frame(0, 8'hA3, 1'b1);
    send_frame(0, 8'h0F, 1'b1);
    idle(20);
    chk("b2b_valid_held", 8'(valid[0]), 8'd1);
    chk("b2b_data_held",  rdata[0],     8'hA3);
    rdy[0] = 1'b1;
    idle(1);
    chk("b2b_valid_drop", 8'(valid[0]), 8'd0);

    // Short low glitch on an idle line, then a good frame
    ser[0] = 1'b0;
    idle(4);
    ser[0] = 1'b1;
    idle(48);
    chk("glitch_valid", 8'(valid[0]), 8'd0);
    expect_ev(0, EV_DATA, 8'h96);
    send_frame(0, 8'h96, 1'b1);
    idle(32);

    // Framing error, line held low (break), then recovery
    expect_ev(0, EV_FE, 8'h00);
    send_frame(0, 8'hFF, 1'b0);
    idle(40 * 16);
    chk("break_valid", 8'(valid[0]), 8'd0);
    ser[0] = 1'b1;
    idle(32);
    expect_ev(0, EV_DATA, 8'h3C);
    send_frame(0, 8'h3C, 1'b1);
    idle(32);

    // Consume on exactly the completion edge of the next byte
    rdy[0] = 1'b0;
    expect_ev(0, EV_DATA, 8'h7E);
    expect_ev(0, EV_DATA, 8'h81);
    send_frame(0, 8'h7E, 1'b1);
    idle(32);
    chk("sim_first_held", rdata[0], 8'h7E);
    fork
      send_frame(0, 8'h81, 1'b1);
      begin
        repeat (2 + 8 + 144) @(posedge clock);
        @(negedge clock);
        rdy[0] = 1'b1;
        @(negedge clock);
        rdy[0] = 1'b0;
      end
    join
    idle(5);
    chk("sim_valid_kept", 8'(valid[0]), 8'd1);
    chk("sim_data_new",   rdata[0],     8'h81);
    rdy[0] = 1'b1;
    idle(2);
    chk("sim_valid_drop", 8'(valid[0]), 8'd0);

    // Reset during data bit 4 with a byte already held
    rdy[0] = 1'b0;
    send_frame(0, 8'h5A, 1'b1);
    idle(32);
    chk("pre_rst_valid", 8'(valid[0]), 8'd1);
    send_partial(0, 8'hE7);
    rstn = 1'b0;
    #1;
    chk("mid_rst_data",  rdata[0],     8'h00);
    chk("mid_rst_valid", 8'(valid[0]), 8'd0);
    chk("mid_rst_ferr",  8'(fe[0]),    8'd0);
    chk("mid_rst_ovr",   8'(ov[0]),    8'd0);
    ser[0] = 1'b1;
    idle(4);
    rstn = 1'b1;
    idle(200);
    chk("post_rst_valid", 8'(valid[0]), 8'd0);
    rdy[0] = 1'b1;
    expect_ev(0, EV_DATA, 8'hC5);
    send_frame(0, 8'hC5, 1'b1);
    idle(32);

    // Bit-period sweep
    rdy[1] = 1'b1;
    single_byte(1, 8'h55);
    rdy[2] = 1'b1;
    single_byte(2, 8'h55);

    idle(10);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL sb_missing: inst %0d %s %02h required, never seen", e.inst, e.kind.name(), e.data);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
